ucaspian_neuron_core: RTL

Consumes per-neuron charge flushed by the dendrite stage and integrates it into a 256-entry membrane potential store. Applies lazy time-based leak and threshold compare, and emits fire events to the downstream axon/synapse dispatcher through a small output FIFO. Sits directly downstream of the dendrite in the uCaspian core pipeline.

---
 rtl/ucaspian_neuron_core.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ucaspian_neuron_core.sv
// ucaspian_neuron_core: integrates dendrite charge into a 256-entry membrane store with lazy leak, threshold fire and an output fire FIFO
//   clk, reset                       : clock, synchronous active-high reset
//   enable                           : when low, accepted charge integrates as 0
//   clear_act / clear_config         : level clear of potentials (and config), clear_done pulses at sweep end
//   next_step / step_done            : timestep advance, core idle indication
//   neuron_addr/charge/vld/rdy       : incoming charge stream
//   cfg_addr/threshold/leak_en/wr    : per-neuron config write port
//   fire_addr/vld/rdy                : outgoing fire events
module ucaspian_neuron_core #(
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_NEURONS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_act,
  input  logic        clear_config,
  output logic        clear_done,
  input  logic        next_step,
  output logic        step_done,
  input  logic [7:0]  neuron_addr,
  input  logic [15:0] neuron_charge,
  input  logic        neuron_vld,
  output logic        neuron_rdy,
  input  logic [7:0]  cfg_addr,
  input  logic [15:0] cfg_threshold,
  input  logic        cfg_leak_en,
  input  logic        cfg_wr,
  output logic [7:0]  fire_addr,
  output logic        fire_vld,
  input  logic        fire_rdy
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FD = FIFO_DEPTH[FW:0];
  localparam logic [0:0] CLR_SWEEP = 1'b0;
  localparam logic [0:0] CLR_HOLD  = 1'b1;

  logic [23:0] pmem [NUM_NEURONS];
  logic [16:0] cmem [NUM_NEURONS];
  logic [23:0] prd;
  logic [16:0] crd;
  logic [7:0] step, clr_idx;
  logic [0:0] clr_st;
  logic clr_lvl, clr_wr, accept;
  logic s1_vld;
  logic [7:0] s1_addr, s1_step;
  logic signed [15:0] s1_chg;
  logic s2_vld, s2_fire;
  logic [7:0] s2_addr, s2_step;
  logic signed [15:0] s2_sum;
  logic w_vld;
  logic [7:0] w_addr, w_tag;
  logic signed [15:0] w_pot;
  logic [7:0] fmem [FIFO_DEPTH];
  logic [FW-1:0] wp, rp;
  logic [FW:0] cnt, free, infl;
  logic push, pop, fire;
  logic [7:0] cur_tag, delta;
  logic [3:0] sh;
  logic signed [15:0] s2_pot, cur_pot, lk_pot, sum;
  logic [16:0] wide;

  assign clr_lvl = clear_act || clear_config;
  assign clr_wr = clr_lvl && clr_st == CLR_SWEEP;
  // every in-flight item holds a FIFO slot whether or not it ends up firing, so the FIFO cannot overflow
  assign free = FD - cnt;
  assign infl = {{FW{1'b0}}, s1_vld} + {{FW{1'b0}}, s2_vld};
  assign neuron_rdy = !clr_lvl && !reset && free > infl;
  assign accept = neuron_vld && neuron_rdy;
  assign fire_vld = cnt != '0;
  assign fire_addr = fire_vld ? fmem[rp] : 8'd0;
  assign step_done = !reset && !s1_vld && !s2_vld && !fire_vld && !neuron_vld && !clr_lvl;
  assign push = s2_vld && s2_fire && !clr_lvl;
  assign pop = fire_vld && fire_rdy;

  // the RAM read in S1 misses the S2 write of this cycle and the write landing on the read edge; forward both
  always_comb begin
    s2_pot = s2_fire ? 16'sd0 : s2_sum;
    cur_pot = (s2_vld && s2_addr == s1_addr) ? s2_pot : (w_vld && w_addr == s1_addr) ? w_pot : $signed(prd[15:0]);
    cur_tag = (s2_vld && s2_addr == s1_addr) ? s2_step : (w_vld && w_addr == s1_addr) ? w_tag : prd[23:16];
    delta = s1_step - cur_tag;
    sh = delta > 8'd15 ? 4'd15 : delta[3:0];
    lk_pot = crd[0] ? cur_pot >>> sh : cur_pot;
    wide = {lk_pot[15], lk_pot} + {s1_chg[15], s1_chg};
    sum = wide[16:15] == 2'b01 ? 16'sh7fff : wide[16:15] == 2'b10 ? 16'sh8000 : $signed(wide[15:0]);
    fire = sum >= $signed(crd[16:1]);
  end

  always_ff @(posedge clk) begin
    if (clr_wr) pmem[clr_idx] <= '0;
    else if (s2_vld && !clr_lvl) pmem[s2_addr] <= {s2_step, s2_pot};
    if (clr_wr && clear_config) cmem[clr_idx] <= '0;
    else if (cfg_wr && !clr_lvl) cmem[cfg_addr] <= {cfg_threshold, cfg_leak_en};
    prd <= pmem[neuron_addr];
    crd <= cmem[neuron_addr];
  end

  always_ff @(posedge clk) begin
    s1_addr <= neuron_addr;
    s1_chg <= enable ? $signed(neuron_charge) : 16'sd0;
    s1_step <= step;
    s2_addr <= s1_addr;
    s2_step <= s1_step;
    s2_sum <= sum;
    s2_fire <= fire;
    w_addr <= s2_addr;
    w_tag <= s2_step;
    w_pot <= s2_pot;
    if (push) fmem[wp] <= s2_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      w_vld <= 1'b0;
      step <= 8'd0;
      clr_st <= CLR_SWEEP;
      clr_idx <= 8'd0;
      clear_done <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld && !clr_lvl;
      w_vld <= s2_vld && !clr_lvl;
      step <= clr_lvl ? 8'd0 : step + {7'd0, next_step};
      clear_done <= clr_wr && clr_idx == 8'hff;
      clr_st <= !clr_lvl ? CLR_SWEEP : (clr_wr && clr_idx == 8'hff) ? CLR_HOLD : clr_st;
      clr_idx <= clr_wr ? clr_idx + 8'd1 : 8'd0;
      if (clr_lvl) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + {{FW{1'b0}}, push} - {{FW{1'b0}}, pop};
      end
    end
  end
endmodule
